// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle shift/rotate sequencer, one bit position per clock.
// Define ALU_SHIFT_RC_EN to make ops 2/3 rotate through carry; otherwise they alias ROL/ROR.
module alu_shift_seq #(
  parameter int WIDTH    = 16,
  parameter int CNT_MASK = 31
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic             byte_mode_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [7:0]       count_in_i,
  input  logic             cf_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cf_out_o,
  output logic             of_out_o,
  output logic             flags_upd_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [7:0]       MASK      = 8'(CNT_MASK);
  localparam logic [WIDTH-1:0] BYTE_MASK = WIDTH'(8'hff);
  state_t           state_q;
  logic [2:0]       op_q;
  logic             bm_q, om_q;
  logic [7:0]       rem_q;
  logic [WIDTH-1:0] val_q, result_q;
  logic             busy_q, done_q, cf_out_q, of_out_q, flags_upd_q;
`ifdef ALU_SHIFT_RC_EN
  logic             cf_q;
`endif
  logic [7:0]       n;
  logic [WIDTH-1:0] op_data, val_d;
  logic             msb, rot_in, fill, cf_d, fm, fm1, of_d;
  always_comb begin
    n       = count_in_i & MASK;
    op_data = byte_mode_i ? (data_in_i & BYTE_MASK) : data_in_i;
    msb     = bm_q ? val_q[7] : val_q[WIDTH-1];
    rot_in  = op_q[0] ? val_q[0] : msb;
`ifdef ALU_SHIFT_RC_EN
    fill    = op_q[2] ? (op_q[1] & op_q[0] & msb) : (op_q[1] ? cf_q : rot_in);
`else
    fill    = op_q[2] ? (op_q[1] & op_q[0] & msb) : rot_in;
`endif
    val_d   = op_q[0] ? (bm_q ? {{(WIDTH-8){1'b0}}, fill, val_q[7:1]} : {fill, val_q[WIDTH-1:1]})
                      : (bm_q ? {{(WIDTH-8){1'b0}}, val_q[6:0], fill} : {val_q[WIDTH-2:0], fill});
    cf_d    = op_q[0] ? val_q[0] : msb;
    fm      = bm_q ? val_d[7] : val_d[WIDTH-1];
    fm1     = bm_q ? val_d[6] : val_d[WIDTH-2];
    // left ops: msb^CF; ROR/RCR: top two bits; SHR: original msb; SAR: 0
    of_d    = !op_q[0] ? (fm ^ cf_d) : (op_q[2] ? (!op_q[1] & om_q) : (fm ^ fm1));
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      op_q        <= '0;
      bm_q        <= 1'b0;
      om_q        <= 1'b0;
      rem_q       <= '0;
      val_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cf_out_q    <= 1'b0;
      of_out_q    <= 1'b0;
      flags_upd_q <= 1'b0;
`ifdef ALU_SHIFT_RC_EN
      cf_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          op_q  <= op_i;
          bm_q  <= byte_mode_i;
          om_q  <= byte_mode_i ? data_in_i[7] : data_in_i[WIDTH-1];
          val_q <= op_data;
          rem_q <= n;
`ifdef ALU_SHIFT_RC_EN
          cf_q  <= cf_in_i;
`endif
          if (n == 8'd0) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            result_q    <= op_data;
            cf_out_q    <= cf_in_i;
            of_out_q    <= 1'b0;
            flags_upd_q <= 1'b0;
          end else begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          val_q <= val_d;
          rem_q <= rem_q - 8'd1;
`ifdef ALU_SHIFT_RC_EN
          cf_q  <= cf_d;
`endif
          if (rem_q == 8'd1) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= val_d;
            cf_out_q    <= cf_d;
            of_out_q    <= of_d;
            flags_upd_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign cf_out_o    = cf_out_q;
  assign of_out_o    = of_out_q;
  assign flags_upd_o = flags_upd_q;
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed scoreboard bench for alu_shift_seq (word/byte, all ops, count edges, reset abort).
module tb_alu_shift_seq;
  typedef struct {
    string       tag;
    logic [15:0] r;
    logic        c;
    logic        o;
    logic        u;
    int          lat;
  } exp_t;
`ifdef ALU_SHIFT_RC_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic        clk = 1'b0, reset_i = 1'b1, start_i = 1'b0, byte_mode_i = 1'b0, cf_in_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [15:0] data_in_i = '0;
  logic [7:0]  count_in_i = '0;
  logic        busy_o, done_o, cf_out_o, of_out_o, flags_upd_o;
  logic [15:0] result_o;
  int          n_checks = 0, n_fail = 0;
  exp_t        sb[$];
  always #5 clk = ~clk;
  alu_shift_seq dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .op_i(op_i), .byte_mode_i(byte_mode_i),
    .data_in_i(data_in_i), .count_in_i(count_in_i), .cf_in_i(cf_in_i), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .cf_out_o(cf_out_o), .of_out_o(of_out_o),
    .flags_upd_o(flags_upd_o)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // closed-form reference: whole-count shifts and ring rotations rather than bit stepping
  function automatic exp_t model(input logic [2:0] op, input logic bm, input logic [15:0] d,
                                 input logic [7:0] c, input logic ci);
    exp_t e;
    int w = bm ? 8 : 16;
    int n = int'(c & 8'd31);
    int k;
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] v = {48'd0, d} & m;
    logic [63:0] r, t, ring, rm;
    logic signed [63:0] s;
    logic [2:0] eo = (!RC && op[2:1] == 2'b01) ? {2'b00, op[0]} : op;
    e.lat = n + 1;
    e.u   = (n != 0);
    r     = v;
    e.c   = ci;
    rm    = (m << 1) | 64'd1;
    if (n != 0) begin
      case (eo)
        3'd0: begin k = n % w; r = ((v << k) | (v >> (w - k))) & m; e.c = r[0]; end
        3'd1: begin k = n % w; r = ((v >> k) | (v << (w - k))) & m; e.c = r[w-1]; end
        3'd2: begin
          ring = v | (64'(ci) << w); k = n % (w + 1);
          ring = ((ring << k) | (ring >> (w + 1 - k))) & rm;
          r = ring & m; e.c = ring[w];
        end
        3'd3: begin
          ring = v | (64'(ci) << w); k = n % (w + 1);
          ring = ((ring >> k) | (ring << (w + 1 - k))) & rm;
          r = ring & m; e.c = ring[w];
        end
        3'd5: begin t = v >> (n - 1); e.c = t[0]; r = v >> n; end
        3'd7: begin
          s = $signed(v << (64 - w));
          s = s >>> (64 - w);
          s = s >>> (n - 1);
          e.c = s[0];
          s = s >>> 1;
          r = s & m;
        end
        default: begin t = v << n; r = t & m; e.c = t[w]; end
      endcase
    end
    e.o = (n == 0 || eo == 3'd7) ? 1'b0 : !eo[0] ? (r[w-1] ^ e.c) : (eo == 3'd5) ? v[w-1] : (r[w-1] ^ r[w-2]);
    e.r = r[15:0];
    return e;
  endfunction
  task automatic run(input string tag, input logic [2:0] op, input logic bm, input logic [15:0] d,
                     input logic [7:0] c, input logic ci, input bit poke);
    exp_t        e;
    int          cyc = 1, nb = 0;
    bit          stable = 1'b1;
    logic [15:0] held = result_o;
    e = model(op, bm, d, c, ci);
    e.tag = tag;
    sb.push_back(e);
    op_i = op; byte_mode_i = bm; data_in_i = d; count_in_i = c; cf_in_i = ci; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = ~op; data_in_i = ~d; cf_in_i = ~ci; count_in_i = 8'd0;
    while (!done_o && cyc < 100) begin
      if (busy_o) nb++;
      if (result_o !== held) stable = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    check({e.tag, ".done"}, done_o, 1);
    check({e.tag, ".res"}, result_o, e.r);
    check({e.tag, ".cf"}, cf_out_o, e.c);
    check({e.tag, ".of"}, of_out_o, e.o);
    check({e.tag, ".upd"}, flags_upd_o, e.u);
    check({e.tag, ".lat"}, cyc, e.lat);
    check({e.tag, ".busy_cycles"}, nb, e.lat - 1);
    check({e.tag, ".stable"}, stable, 1);
    if (poke) start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check({e.tag, ".idle_busy"}, busy_o, 0);
    check({e.tag, ".idle_done"}, done_o, 0);
    check({e.tag, ".held"}, result_o, e.r);
  endtask
  initial begin
    int pulses;
    #1;
    check("reset.busy", busy_o, 0);
    check("reset.done", done_o, 0);
    check("reset.res", result_o, 0);
    check("reset.cf", cf_out_o, 0);
    check("reset.of", of_out_o, 0);
    check("reset.upd", flags_upd_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    run("shl_w1",     3'd4, 1'b0, 16'h8001, 8'd1,   1'b0, 1'b0);
    run("ror_b4",     3'd1, 1'b1, 16'h0081, 8'd4,   1'b0, 1'b1);
    run("sar_w15",    3'd7, 1'b0, 16'h8000, 8'd15,  1'b0, 1'b0);
    run("cnt_mask0",  3'd4, 1'b0, 16'h1234, 8'h20,  1'b1, 1'b1);
    run("rcl_w2",     3'd2, 1'b0, 16'h8000, 8'd2,   1'b0, 1'b0);
    run("shr_w16",    3'd5, 1'b0, 16'h8001, 8'd16,  1'b0, 1'b0);
    run("rol_b9",     3'd0, 1'b1, 16'hFF5A, 8'd9,   1'b1, 1'b0);
    run("rcr_w17",    3'd3, 1'b0, 16'h0001, 8'd17,  1'b1, 1'b0);
    run("sar_b31",    3'd7, 1'b1, 16'h3C80, 8'd31,  1'b0, 1'b0);
    run("shl6_w1",    3'd6, 1'b0, 16'h4000, 8'd1,   1'b0, 1'b0);
    run("ror_w31",    3'd1, 1'b0, 16'h0001, 8'hFF,  1'b0, 1'b0);
    run("zero_b",     3'd3, 1'b1, 16'hABCD, 8'd0,   1'b0, 1'b0);
    run("rcl_b5",     3'd2, 1'b1, 16'h00A5, 8'd5,   1'b1, 1'b0);
    run("shr_b3",     3'd5, 1'b1, 16'h7F96, 8'd3,   1'b1, 1'b0);
    op_i = 3'd4; byte_mode_i = 1'b0; data_in_i = 16'h0003; count_in_i = 8'd10; cf_in_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd5; count_in_i = 8'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("abort.busy_t4", busy_o, 1);
    check("abort.done_t4", done_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1;
    check("abort.busy", busy_o, 0);
    check("abort.done", done_o, 0);
    check("abort.res", result_o, 0);
    check("abort.cf", cf_out_o, 0);
    check("abort.upd", flags_upd_o, 0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 1) reset_i = 1'b0;
      if (done_o) pulses++;
    end
    check("abort.no_done", pulses, 0);
    run("post_reset", 3'd4, 1'b0, 16'h0003, 8'd10, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
